// File: rtl/mod_n_bit_counter_fsm.sv
// mod_n_bit_counter_fsm
//   Multi-channel serial residue monitor. Each of NCH single-bit channels keeps
//   a zero-count residue and a one-count residue, both modulo MOD, and flags
//   when either residue is zero ("count divisible by MOD").
//
//   Optional framed mode (define MOD_N_FRAME_MODE_EN): accepted samples are
//   grouped into FRAME_LEN-sample frames. At the end of each frame the
//   divisibility flags are captured and frame_done_o pulses for one cycle.
//   The residues then restart from zero. Without the macro, the frame
//   outputs are tied low.
//
// Ports
//   clk_i              rising-edge clock
//   reset_i            synchronous active-high reset
//   in_valid_i         qualifies in_i this cycle
//   in_i[NCH]          one serial bit per channel
//   clear_i            synchronous soft clear of residues and frame position
//   zeros_res_o        zero-count residues, channel i at [i*CW +: CW]
//   ones_res_o         one-count residues, same packing
//   zeros_div_o[NCH]   1 when the zero residue of a channel is 0
//   ones_div_o[NCH]    1 when the one residue of a channel is 0
//   frame_done_o       single-cycle pulse after the last sample of a frame
//   frame_zeros_div_o  zeros_div captured at frame end
//   frame_ones_div_o   ones_div captured at frame end
module mod_n_bit_counter_fsm #(
    parameter int unsigned NCH       = 4,
    parameter int unsigned MOD       = 2,
    parameter int unsigned FRAME_LEN = 8,
    localparam int unsigned CW       = (MOD > 2) ? $clog2(MOD) : 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              in_valid_i,
    input  logic [NCH-1:0]    in_i,
    input  logic              clear_i,
    output logic [NCH*CW-1:0] zeros_res_o,
    output logic [NCH*CW-1:0] ones_res_o,
    output logic [NCH-1:0]    zeros_div_o,
    output logic [NCH-1:0]    ones_div_o,
    output logic              frame_done_o,
    output logic [NCH-1:0]    frame_zeros_div_o,
    output logic [NCH-1:0]    frame_ones_div_o
);

    if (NCH < 1) begin : g_bad_nch
        $error("NCH must be at least 1");
    end
    if (MOD < 2) begin : g_bad_mod
        $error("MOD must be at least 2");
    end
    if (FRAME_LEN < 1) begin : g_bad_frame_len
        $error("FRAME_LEN must be at least 1");
    end

    localparam logic [CW-1:0] ResMax = CW'(MOD - 1);

    logic [NCH*CW-1:0] zeros_res_q, zeros_res_d;
    logic [NCH*CW-1:0] ones_res_q, ones_res_d;
    // Residues as they would be after counting the current sample.
    logic [NCH*CW-1:0] zeros_bump, ones_bump;
    logic              accept;
    logic              frame_end;

    assign accept = in_valid_i & ~clear_i;

    always_comb begin
        zeros_bump = zeros_res_q;
        ones_bump  = ones_res_q;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (in_i[i]) begin
                ones_bump[i*CW +: CW] = (ones_res_q[i*CW +: CW] == ResMax) ? '0 :
                                        ones_res_q[i*CW +: CW] + CW'(1);
            end else begin
                zeros_bump[i*CW +: CW] = (zeros_res_q[i*CW +: CW] == ResMax) ? '0 :
                                         zeros_res_q[i*CW +: CW] + CW'(1);
            end
        end
    end

    // A completed frame restarts the residues so the next frame starts clean.
    always_comb begin
        zeros_res_d = zeros_res_q;
        ones_res_d  = ones_res_q;
        if (clear_i || frame_end) begin
            zeros_res_d = '0;
            ones_res_d  = '0;
        end else if (accept) begin
            zeros_res_d = zeros_bump;
            ones_res_d  = ones_bump;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            zeros_res_q <= '0;
            ones_res_q  <= '0;
        end else begin
            zeros_res_q <= zeros_res_d;
            ones_res_q  <= ones_res_d;
        end
    end

    assign zeros_res_o = zeros_res_q;
    assign ones_res_o  = ones_res_q;

    always_comb begin
        for (int unsigned i = 0; i < NCH; i++) begin
            zeros_div_o[i] = (zeros_res_q[i*CW +: CW] == '0);
            ones_div_o[i]  = (ones_res_q[i*CW +: CW] == '0);
        end
    end

`ifdef MOD_N_FRAME_MODE_EN
    localparam int unsigned   PW      = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [PW-1:0] PosLast = PW'(FRAME_LEN - 1);

    typedef enum logic [0:0] {StCount, StLast} frame_st_e;
    // With one-sample frames every accepted sample closes a frame.
    localparam frame_st_e StInit = (FRAME_LEN == 1) ? StLast : StCount;

    frame_st_e      state_q;
    logic [PW-1:0]  pos_q;
    logic           frame_done_q;
    logic [NCH-1:0] frame_zeros_div_q, frame_ones_div_q;
    logic [NCH-1:0] zeros_bump_div, ones_bump_div;

    always_comb begin
        for (int unsigned i = 0; i < NCH; i++) begin
            zeros_bump_div[i] = (zeros_bump[i*CW +: CW] == '0);
            ones_bump_div[i]  = (ones_bump[i*CW +: CW] == '0);
        end
    end

    assign frame_end = accept & (state_q == StLast);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q           <= StInit;
            pos_q             <= '0;
            frame_done_q      <= 1'b0;
            frame_zeros_div_q <= '0;
            frame_ones_div_q  <= '0;
        end else begin
            frame_done_q <= frame_end;
            if (clear_i) begin
                state_q <= StInit;
                pos_q   <= '0;
            end else if (accept) begin
                unique case (state_q)
                    StCount: begin
                        pos_q   <= pos_q + PW'(1);
                        state_q <= (pos_q + PW'(1) == PosLast) ? StLast : StCount;
                    end
                    StLast: begin
                        pos_q             <= '0;
                        state_q           <= StInit;
                        frame_zeros_div_q <= zeros_bump_div;
                        frame_ones_div_q  <= ones_bump_div;
                    end
                    default: begin
                        pos_q   <= '0;
                        state_q <= StInit;
                    end
                endcase
            end
        end
    end

    assign frame_done_o      = frame_done_q;
    assign frame_zeros_div_o = frame_zeros_div_q;
    assign frame_ones_div_o  = frame_ones_div_q;
`else
    assign frame_end         = 1'b0;
    assign frame_done_o      = 1'b0;
    assign frame_zeros_div_o = '0;
    assign frame_ones_div_o  = '0;
`endif

endmodule

// File: doc/mod_n_bit_counter_fsm.md
Name: mod_n_bit_counter_fsm

Overview:
Multi-channel serial bit-statistics tracker. It generalises the even/odd 0s/1s detector to NCH independent 1-bit input channels. Zeros and ones are counted modulo a configurable MOD, and each channel reports "count divisible by MOD" flags. It sits directly behind serial data sources as a lightweight parity/residue monitor. An optional framed mode evaluates fixed-length windows and reports per-frame results.

Parameters:
NCH, 4, number of independent serial channels (>=1)
MOD, 2, counting modulus (>=2); MOD=2 gives even/odd behaviour
FRAME_LEN, 8, samples per frame in framed mode (>=1); ignored when the feature is compiled out
CW (localparam), max(1, clog2(MOD)), residue width per counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  qualifies in[] this cycle; samples are taken only when high
in  input  NCH  one serial bit per channel; bit i is channel i
clear  input  1  synchronous soft clear of all residues and the frame position
zeros_res  output  NCH*CW  per-channel zero-count residue; channel i occupies [i*CW +: CW]
ones_res  output  NCH*CW  per-channel one-count residue, same packing
zeros_div  output  NCH  1 when zeros_res[i]==0
ones_div  output  NCH  1 when ones_res[i]==0
frame_done  output  1  single-cycle pulse at the end of each frame
frame_zeros_div  output  NCH  zeros_div captured at frame end
frame_ones_div  output  NCH  ones_div captured at frame end

Behaviour:
- Single clock domain. All state and outputs are registered.
- Priority each cycle: reset > clear > in_valid.
- Reset values:
  - zeros_res = ones_res = 0, so zeros_div and ones_div are all ones (zero count treated as divisible).
  - frame_done = 0.
  - frame_zeros_div = frame_ones_div = 0.
  - Frame position = 0.
- Accepted sample (in_valid=1, clear=0), per channel i:
  - in[i]=0: zeros_res[i] <= (zeros_res[i]==MOD-1) ? 0 : zeros_res[i]+1; ones_res[i] holds.
  - in[i]=1: same rule applied to ones_res[i]; zeros_res[i] holds.
  - Wrap-around is exact at MOD-1 -> 0. A residue never exceeds MOD-1, including when MOD is not a power of two.
- Latency: outputs reflect all samples accepted up to and including the previous clock edge (1 cycle from sample to flag).
- in_valid=0: all state holds and no pulse is generated.
- clear=1: residues <= 0 and frame position <= 0. Any in_valid sample that cycle is dropped. frame_done is not generated. frame_* result registers hold their last values.
- The *_div flags are derived from the registered residues, so they change only on a clock edge.

Optional Feature:
Macro: MOD_N_FRAME_MODE_EN
- Defined:
  - A frame FSM with states COUNT and LAST. The frame position counter runs 0..FRAME_LEN-1 on accepted samples; the state is LAST when position==FRAME_LEN-1.
  - On the accepted sample in LAST:
    - frame_zeros_div / frame_ones_div capture the divisibility including that sample.
    - frame_done pulses high on the next cycle, for exactly one cycle.
    - Residues restart at 0, so the next frame starts clean; they do not include the last sample.
    - Position returns to 0.
  - FRAME_LEN=1: every accepted sample ends a frame. frame_done follows in_valid by one cycle, and the residues are always 0 afterwards.
  - reset or clear mid-frame aborts the frame with no pulse.
- Undefined:
  - Free-running counting with no frame FSM and no position counter.
  - frame_done, frame_zeros_div and frame_ones_div are tied to 0.

Test Plan:
1. Reset/basic (NCH=1, MOD=2): reset for 1 cycle, then in=0,1,0,1,1,0 with in_valid=1.
   - After the 1st sample: zeros_div=0, ones_div=1.
   - After the 6th sample: zeros_res=1, ones_res=1, zeros_div=0, ones_div=0.
2. Non-power-of-two wrap (MOD=3, CW=2): seven consecutive 1s on ch0.
   - ones_res goes 1,2,0,1,2,0,1.
   - ones_div=1 after samples 3 and 6 only; zeros_res stays 0.
3. Channel independence/gating (NCH=4, MOD=2):
   - in=4'b1010 for 3 cycles -> ones_div=4'b0101, zeros_div=4'b1010.
   - A cycle with in_valid=0 and in=4'b1111 changes nothing.
4. Clear priority:
   - With residues nonzero, assert clear with in_valid=1, in=1 -> next cycle all residues 0 and all *_div=1 (sample dropped).
   - Reset asserted together with clear gives the same reset values.
5. Framed (MOD_N_FRAME_MODE_EN, FRAME_LEN=8, MOD=3, NCH=1): eight samples 1,1,1,0,1,1,1,0.
   - frame_done pulses exactly once, the cycle after the 8th sample.
   - frame_ones_div=1 (6 ones), frame_zeros_div=0 (2 zeros); residues then read 0.
6. Framed abort: clear after 5 samples.
   - No frame_done.
   - The next full 8 samples produce exactly one pulse.
   - The previous frame_* values hold until that pulse.
